riptide_d_cache: RTL

//  Direct-mapped, write-back data cache. It sits between the IO stages (RC read, WC write) and

---
 rtl/riptide_cache_pkg.sv | 23 ++
 rtl/d_cache_tag_array.sv | 43 ++++
 rtl/riptide_d_cache.sv | 87 ++++++++
 3 files changed

// File: rtl/riptide_cache_pkg.sv
// riptide_cache_pkg: data cache geometry, FSM states and address slicing helpers
package riptide_cache_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int INDEX_BITS = 4;
    localparam int OFFSET_BITS = 2;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS;
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = LINES << OFFSET_BITS;

    typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

    function automatic logic [TAG_BITS-1:0] addr_tag(input logic [ADDR_WIDTH-1:0] a);
        return a[ADDR_WIDTH-1 -: TAG_BITS];
    endfunction

    function automatic logic [INDEX_BITS-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFSET_BITS +: INDEX_BITS];
    endfunction

    function automatic logic [OFFSET_BITS-1:0] addr_off(input logic [ADDR_WIDTH-1:0] a);
        return a[OFFSET_BITS-1:0];
    endfunction
endpackage

// File: rtl/d_cache_tag_array.sv
// d_cache_tag_array: valid/dirty/tag state with read and write lookup ports and one update port
module d_cache_tag_array
    import riptide_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  RST,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    input  logic [INDEX_BITS-1:0] wr_idx,
    output logic                  wr_valid,
    output logic                  wr_dirty,
    output logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  upd_en,
    input  logic [INDEX_BITS-1:0] upd_idx,
    input  logic [TAG_BITS-1:0]   upd_tag,
    input  logic                  upd_dirty
);
    logic [LINES-1:0] valid;
    logic [LINES-1:0] dirty;
    logic [TAG_BITS-1:0] tags [LINES];

    always_ff @(posedge clk) begin
        if (RST) begin
            valid <= '0;
            dirty <= '0;
        end else if (upd_en) begin
            valid[upd_idx] <= 1'b1;
            dirty[upd_idx] <= upd_dirty;
        end
    end

    always_ff @(posedge clk)
        if (upd_en) tags[upd_idx] <= upd_tag;

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign wr_valid = valid[wr_idx];
    assign wr_dirty = dirty[wr_idx];
    assign wr_tag   = tags[wr_idx];
endmodule

// File: rtl/riptide_d_cache.sv
// riptide_d_cache: direct-mapped write-back byte data cache with single-refill miss FSM
module riptide_d_cache
    import riptide_cache_pkg::*;
(
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  cache_rd,
    input  logic [ADDR_WIDTH-1:0] cache_rd_address,
    output logic [7:0]            cache_data_out,
    input  logic                  cache_wr,
    input  logic [ADDR_WIDTH-1:0] cache_wr_address,
    input  logic [7:0]            cache_data_in,
    output logic                  d_cache_miss,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [7:0]            mem_data_out,
    input  logic [7:0]            mem_data_in,
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    input  logic                  mem_ready
);
    state_t state;
    logic [OFFSET_BITS-1:0] beat;
    logic [TAG_BITS-1:0] miss_tag, victim_tag, rd_tag, wr_tag;
    logic [INDEX_BITS-1:0] miss_idx;
    logic [7:0] data [WORDS];
    logic rd_valid, rd_dirty, wr_valid, wr_dirty;
    logic idle, rd_hit, wr_hit, rd_miss, wr_miss, wr_commit, last, fill_beat, fill_done;
    logic [ADDR_WIDTH-1:0] svc_addr;

    d_cache_tag_array u_tags (
        .clk       (clk),
        .RST       (RST),
        .rd_idx    (addr_idx(cache_rd_address)),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .wr_idx    (addr_idx(cache_wr_address)),
        .wr_valid  (wr_valid),
        .wr_dirty  (wr_dirty),
        .wr_tag    (wr_tag),
        .upd_en    (fill_done || wr_commit),
        .upd_idx   (fill_done ? miss_idx : addr_idx(cache_wr_address)),
        .upd_tag   (fill_done ? miss_tag : addr_tag(cache_wr_address)),
        .upd_dirty (!fill_done)
    );

    assign idle         = state == IDLE;
    assign rd_hit       = rd_valid && rd_tag == addr_tag(cache_rd_address);
    assign wr_hit       = wr_valid && wr_tag == addr_tag(cache_wr_address);
    assign rd_miss      = cache_rd && !rd_hit;
    assign wr_miss      = cache_wr && !wr_hit;
    assign d_cache_miss = rd_miss || wr_miss || ((cache_rd || cache_wr) && !idle);
    // a stalled write is retried, so it only lands once the whole access pair hits
    assign wr_commit    = cache_wr && !d_cache_miss;
    assign svc_addr     = wr_miss ? cache_wr_address : cache_rd_address;
    assign last         = &beat;
    assign fill_beat    = state == FILL && mem_ready;
    assign fill_done    = fill_beat && last;

    assign mem_rd_req     = state == FILL;
    assign mem_wr_req     = state == WRITEBACK;
    assign mem_address    = idle ? '0 : {mem_wr_req ? victim_tag : miss_tag, miss_idx, beat};
    assign mem_data_out   = mem_wr_req ? data[{miss_idx, beat}] : '0;
    assign cache_data_out = (cache_rd && rd_hit) ? data[{addr_idx(cache_rd_address), addr_off(cache_rd_address)}] : '0;

    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
            beat  <= '0;
        end else if (idle) begin
            if (wr_miss || rd_miss) begin
                miss_tag   <= addr_tag(svc_addr);
                miss_idx   <= addr_idx(svc_addr);
                victim_tag <= wr_miss ? wr_tag : rd_tag;
                beat       <= '0;
                state      <= (wr_miss ? wr_valid && wr_dirty : rd_valid && rd_dirty) ? WRITEBACK : FILL;
            end
        end else if (mem_ready) begin
            beat <= last ? '0 : beat + 1'b1;
            if (last) state <= state == WRITEBACK ? FILL : IDLE;
        end
    end

    always_ff @(posedge clk)
        if (fill_beat) data[{miss_idx, beat}] <= mem_data_in;
        else if (wr_commit) data[{addr_idx(cache_wr_address), addr_off(cache_wr_address)}] <= cache_data_in;
endmodule
